// File: rtl/riscv_pkg.sv
// Shared core definitions: data width, architectural register count and
// the hardwired zero register index used by decode, regfile and writeback.
package riscv_pkg;

  localparam int XLEN   = 32;
  localparam int NREGS  = 32;
  localparam int REG_AW = $clog2(NREGS);

  localparam logic [REG_AW-1:0] REG_ZERO = '0;

endpackage

// File: rtl/regfile_sb_bits.sv
// Busy scoreboard: one bit per architectural register with flush > set > clear
// priority, plus the per-read-port busy lookup masked by a same-cycle retire.
module regfile_sb_bits #(
  parameter int NREGS  = 32,
  parameter int NREAD  = 2,
  parameter int AW     = $clog2(NREGS),
  parameter int BYPASS = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                stall,
  input  logic                flush,
  input  logic                iss_valid,
  input  logic [AW-1:0]       iss_rd,
  input  logic                rd_write,
  input  logic [AW-1:0]       rd_addr,
  input  logic [NREAD*AW-1:0] rs_addr,
  output logic [NREAD-1:0]    rs_busy
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;
  logic             set_en_s;
  logic             clr_en_s;

  assign set_en_s = iss_valid & ~stall & (iss_rd != AW'(riscv_pkg::REG_ZERO));
  assign clr_en_s = rd_write & (rd_addr != AW'(riscv_pkg::REG_ZERO));

  // Next-state busy vector; a set on the same register as a clear wins because
  // the newly issued producer is still outstanding.
  always_comb begin
    busy_d    = busy_q;
    busy_d[0] = 1'b0;
    for (int i = 1; i < NREGS; i++) begin
      if (flush) begin
        busy_d[i] = 1'b0;
      end else if (set_en_s && (iss_rd == AW'(i))) begin
        busy_d[i] = 1'b1;
      end else if (clr_en_s && (rd_addr == AW'(i))) begin
        busy_d[i] = 1'b0;
      end else begin
        busy_d[i] = busy_q[i];
      end
    end
  end

  // Busy vector storage, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // Per-port busy lookup; bit 0 is never set, so register 0 reads not busy.
  always_comb begin
    rs_busy = '0;
    for (int k = 0; k < NREAD; k++) begin
      logic [AW-1:0] addr_s;
      logic          retire_s;
      addr_s   = rs_addr[k*AW +: AW];
      retire_s = (BYPASS != 0) && rd_write && (rd_addr == addr_s);
      rs_busy[k] = busy_q[addr_s] & ~retire_s;
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Integer register file with NREAD combinational read ports, optional
// write-to-read bypass and a busy scoreboard for in-order hazard detection.
module regfile_scoreboard #(
  parameter int XLEN   = riscv_pkg::XLEN,
  parameter int NREGS  = riscv_pkg::NREGS,
  parameter int NREAD  = 2,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall,
  input  logic                  flush,
  input  logic [NREAD*AW-1:0]   rs_addr,
  output logic [NREAD*XLEN-1:0] rs_data,
  output logic [NREAD-1:0]      rs_busy,
  input  logic                  iss_valid,
  input  logic [AW-1:0]         iss_rd,
  input  logic                  rd_write,
  input  logic [AW-1:0]         rd_addr,
  input  logic [XLEN-1:0]       rd_data
);

  logic [NREGS-1:0][XLEN-1:0] regs_q;
  logic [NREGS-1:0][XLEN-1:0] regs_d;
  logic                       wr_en_s;

  assign wr_en_s = rd_write & (rd_addr != AW'(riscv_pkg::REG_ZERO));

  // Array next state; entry 0 is never written so it stays zero.
  always_comb begin
    regs_d    = regs_q;
    regs_d[0] = '0;
    for (int i = 1; i < NREGS; i++) begin
      if (wr_en_s && (rd_addr == AW'(i))) begin
        regs_d[i] = rd_data;
      end else begin
        regs_d[i] = regs_q[i];
      end
    end
  end

  // Flop array with async clear so every register has a defined reset value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // Read muxes with optional same-cycle forwarding of the writeback value.
  always_comb begin
    rs_data = '0;
    for (int k = 0; k < NREAD; k++) begin
      logic [AW-1:0] addr_s;
      addr_s = rs_addr[k*AW +: AW];
      if (addr_s == AW'(riscv_pkg::REG_ZERO)) begin
        rs_data[k*XLEN +: XLEN] = '0;
      end else if ((BYPASS != 0) && rd_write && (rd_addr == addr_s)) begin
        rs_data[k*XLEN +: XLEN] = rd_data;
      end else begin
        rs_data[k*XLEN +: XLEN] = regs_q[addr_s];
      end
    end
  end

  regfile_sb_bits #(
    .NREGS  (NREGS),
    .NREAD  (NREAD),
    .AW     (AW),
    .BYPASS (BYPASS)
  ) u_sb (
    .clk       (clk),
    .rst_n     (rst_n),
    .stall     (stall),
    .flush     (flush),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .rd_write  (rd_write),
    .rd_addr   (rd_addr),
    .rs_addr   (rs_addr),
    .rs_busy   (rs_busy)
  );

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: one bypassing and one non-bypassing
// instance share all inputs so forwarding latency can be compared directly.
module tb_regfile_scoreboard;

  localparam int XLEN = 32;
  localparam int AW   = 5;

  logic            clk;
  logic            rst_n;
  logic            stall;
  logic            flush;
  logic [2*AW-1:0] rs_addr;
  logic            iss_valid;
  logic [AW-1:0]   iss_rd;
  logic            rd_write;
  logic [AW-1:0]   rd_addr;
  logic [XLEN-1:0] rd_data;

  logic [2*XLEN-1:0] data_b, data_n;
  logic [1:0]        busy_b, busy_n;

  int n_cmp;
  int n_fail;

  regfile_scoreboard #(.XLEN(32), .NREGS(32), .NREAD(2), .BYPASS(1)) dut_byp (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .rs_addr(rs_addr), .rs_data(data_b), .rs_busy(busy_b),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .rd_write(rd_write), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  regfile_scoreboard #(.XLEN(32), .NREGS(32), .NREAD(2), .BYPASS(0)) dut_nob (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .rs_addr(rs_addr), .rs_data(data_n), .rs_busy(busy_n),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .rd_write(rd_write), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 time unit after a rising edge; checks happen 3 units later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall = 1'b0; flush = 1'b0; iss_valid = 1'b0; iss_rd = 5'd0;
    rd_write = 1'b0; rd_addr = 5'd0; rd_data = 32'd0;
  endtask

  task automatic set_rs(input int a0, input int a1);
    rs_addr = {5'(a1), 5'(a0)};
  endtask

  task automatic test_reset();
    idle();
    set_rs(0, 0);
    rst_n = 1'b0;
    repeat (2) step();
    #3;
    n_cmp++;
    if (busy_b !== 2'b00 || data_b !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_during: busy=%b data=%h expected 00 / 0", busy_b, data_b);
    end
    rst_n = 1'b1;
    step();
    for (int a = 0; a < 32; a++) begin
      set_rs(a, 31 - a);
      #1;
      n_cmp++;
      if (data_b !== 64'd0 || busy_b !== 2'b00 || data_n !== 64'd0 || busy_n !== 2'b00) begin
        n_fail++;
        $display("FAIL reset_read x%0d: data_b=%h busy_b=%b data_n=%h busy_n=%b expected 0",
                 a, data_b, busy_b, data_n, busy_n);
      end
    end
  endtask

  task automatic test_bypass();
    step();
    idle();
    set_rs(5, 5);
    rd_write = 1'b1; rd_addr = 5'd5; rd_data = 32'hDEADBEEF;
    #3;
    n_cmp++;
    if (data_b[31:0] !== 32'hDEADBEEF || data_b[63:32] !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL bypass_same_cycle: got %h expected deadbeef on both ports", data_b);
    end
    n_cmp++;
    if (data_n[31:0] !== 32'd0) begin
      n_fail++;
      $display("FAIL nobypass_same_cycle: got %h expected 00000000", data_n[31:0]);
    end
    step();
    idle();
    #3;
    n_cmp++;
    if (data_n[31:0] !== 32'hDEADBEEF || data_b[31:0] !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL write_next_cycle: byp=%h nob=%h expected deadbeef", data_b[31:0], data_n[31:0]);
    end
  endtask

  task automatic test_zero_reg();
    step();
    idle();
    set_rs(0, 0);
    rd_write = 1'b1; rd_addr = 5'd0; rd_data = 32'h1234;
    iss_valid = 1'b1; iss_rd = 5'd0;
    #3;
    n_cmp++;
    if (data_b !== 64'd0 || busy_b !== 2'b00) begin
      n_fail++;
      $display("FAIL x0_same_cycle: data=%h busy=%b expected 0 / 00", data_b, busy_b);
    end
    step();
    idle();
    #3;
    n_cmp++;
    if (data_b !== 64'd0 || busy_b !== 2'b00 || data_n !== 64'd0 || busy_n !== 2'b00) begin
      n_fail++;
      $display("FAIL x0_after: data_b=%h busy_b=%b data_n=%h busy_n=%b expected 0",
               data_b, busy_b, data_n, busy_n);
    end
  endtask

  task automatic test_issue_writeback();
    step();
    idle();
    set_rs(7, 7);
    iss_valid = 1'b1; iss_rd = 5'd7;
    #3;
    n_cmp++;
    if (busy_b !== 2'b00) begin
      n_fail++;
      $display("FAIL issue_latency: busy=%b expected 00 in issue cycle", busy_b);
    end
    step();
    idle();
    #3;
    n_cmp++;
    if (busy_b !== 2'b11 || busy_n !== 2'b11) begin
      n_fail++;
      $display("FAIL issue_busy: byp=%b nob=%b expected 11", busy_b, busy_n);
    end
    step();
    idle();
    rd_write = 1'b1; rd_addr = 5'd7; rd_data = 32'h55;
    #3;
    n_cmp++;
    if (busy_b !== 2'b00 || data_b[31:0] !== 32'h55) begin
      n_fail++;
      $display("FAIL retire_bypass: busy=%b data=%h expected 00 / 00000055", busy_b, data_b[31:0]);
    end
    n_cmp++;
    if (busy_n !== 2'b11 || data_n[31:0] !== 32'd0) begin
      n_fail++;
      $display("FAIL retire_nobypass: busy=%b data=%h expected 11 / 00000000", busy_n, data_n[31:0]);
    end
    step();
    idle();
    #3;
    n_cmp++;
    if (busy_b !== 2'b00 || busy_n !== 2'b00 || data_n[31:0] !== 32'h55) begin
      n_fail++;
      $display("FAIL retire_after: busy_b=%b busy_n=%b data_n=%h expected 00 / 00 / 00000055",
               busy_b, busy_n, data_n[31:0]);
    end
  endtask

  task automatic test_set_clear();
    step();
    idle();
    iss_valid = 1'b1; iss_rd = 5'd3;
    rd_write = 1'b1; rd_addr = 5'd3; rd_data = 32'h33;
    step();
    idle();
    set_rs(3, 3);
    #3;
    n_cmp++;
    if (busy_b[0] !== 1'b1 || busy_n[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL set_wins: byp=%b nob=%b expected 1", busy_b[0], busy_n[0]);
    end
    stall = 1'b1; iss_valid = 1'b1; iss_rd = 5'd4;
    step();
    idle();
    set_rs(4, 3);
    #3;
    n_cmp++;
    if (busy_b !== 2'b10) begin
      n_fail++;
      $display("FAIL stall_blocks: busy=%b expected 10", busy_b);
    end
    iss_valid = 1'b1; iss_rd = 5'd10;
    rd_write = 1'b1; rd_addr = 5'd3; rd_data = 32'h34;
    step();
    idle();
    set_rs(10, 3);
    #3;
    n_cmp++;
    if (busy_b !== 2'b01 || busy_n !== 2'b01 || data_b[63:32] !== 32'h34) begin
      n_fail++;
      $display("FAIL set_clear_diff: byp=%b nob=%b x3=%h expected 01 / 01 / 00000034",
               busy_b, busy_n, data_b[63:32]);
    end
  endtask

  task automatic test_flush();
    step();
    idle();
    iss_valid = 1'b1; iss_rd = 5'd1;
    step();
    iss_rd = 5'd2;
    step();
    iss_rd = 5'd9;
    step();
    idle();
    set_rs(1, 9);
    #3;
    n_cmp++;
    if (busy_b !== 2'b11) begin
      n_fail++;
      $display("FAIL pre_flush_busy: busy=%b expected 11", busy_b);
    end
    flush = 1'b1;
    iss_valid = 1'b1; iss_rd = 5'd5;
    rd_write = 1'b1; rd_addr = 5'd9; rd_data = 32'hA5;
    step();
    idle();
    set_rs(2, 5);
    #3;
    n_cmp++;
    if (busy_b !== 2'b00 || busy_n !== 2'b00) begin
      n_fail++;
      $display("FAIL flush_x2_x5: byp=%b nob=%b expected 00", busy_b, busy_n);
    end
    set_rs(9, 9);
    #1;
    n_cmp++;
    if (busy_b !== 2'b00 || data_n !== {32'hA5, 32'hA5}) begin
      n_fail++;
      $display("FAIL flush_write_x9: busy=%b data=%h expected 00 / a5 on both ports", busy_b, data_n);
    end
  endtask

  task automatic test_async_reset();
    step();
    idle();
    iss_valid = 1'b1; iss_rd = 5'd6;
    rd_write = 1'b1; rd_addr = 5'd12; rd_data = 32'h77;
    step();
    idle();
    set_rs(12, 6);
    #1;
    n_cmp++;
    if (data_b[31:0] !== 32'h77 || busy_b[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_state: x12=%h busy6=%b expected 00000077 / 1", data_b[31:0], busy_b[1]);
    end
    rst_n = 1'b0;
    #2;
    n_cmp++;
    if (data_b !== 64'd0 || busy_b !== 2'b00 || data_n !== 64'd0 || busy_n !== 2'b00) begin
      n_fail++;
      $display("FAIL async_reset: data_b=%h busy_b=%b data_n=%h busy_n=%b expected 0",
               data_b, busy_b, data_n, busy_n);
    end
    rst_n = 1'b1;
    step();
    set_rs(9, 5);
    #3;
    n_cmp++;
    if (data_b !== 64'd0) begin
      n_fail++;
      $display("FAIL after_reset_array: data=%h expected 0", data_b);
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    rs_addr = '0;
    idle();
    test_reset();
    test_bypass();
    test_zero_reg();
    test_issue_writeback();
    test_set_clear();
    test_flush();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
